// File: rtl/pqr5_core_pkg.sv
// pqr5_core_pkg
//   Core-wide constants shared by the pqr5 subsystem blocks.
//   DSIZE : width of a RAM data word in bits.
package pqr5_core_pkg;
  localparam int DSIZE = 32;
endpackage

// File: rtl/pqr5_subsystem_pkg.sv
// pqr5_subsystem_pkg
//   Types and constants shared by pqr5 subsystem blocks.
//   dump_state_t : state encoding of the memory dump streamer.
//   BYTE_SHIFT   : word index -> byte address shift (32-bit words).
package pqr5_subsystem_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    EMIT  = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5
  } dump_state_t;

  localparam int BYTE_SHIFT = 2;
endpackage

// File: rtl/pqr5_mem_dump_streamer.sv
// pqr5_mem_dump_streamer
//   Walks a subsystem RAM (IMEM/DMEM) from word 0 to DEPTH-1 on a start pulse
//   and emits one {byte address, data word} beat per word on a valid/ready
//   stream, so the RAM contents can be pulled out over a debug transport.
//
//   Ports
//     clk, srst      clock, synchronous active-high reset
//     start_i        begin a dump (ignored while busy_o)
//     busy_o         dump in progress (FETCH/LATCH/EMIT/CSUM/DONE)
//     done_o         one-cycle pulse after the final beat handshake
//     mem_re_o       RAM read enable
//     mem_addr_o     RAM word address
//     mem_rdata_i    RAM read data, valid one cycle after mem_re_o
//     out_valid_o    stream beat valid
//     out_ready_i    stream sink ready
//     out_addr_o     byte address of the beat (word index * 4)
//     out_data_o     data word of the beat
//     out_last_o     final beat of the dump
//
//   Build option
//     PQR5_DUMP_CSUM_EN : append one extra beat at byte address DEPTH*4
//                         carrying the XOR of all dumped words; that beat,
//                         not the last data word, carries out_last_o.
module pqr5_mem_dump_streamer
  import pqr5_core_pkg::*;
  import pqr5_subsystem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mem_re_o,
  output logic [AW-1:0]    mem_addr_o,
  input  logic [DSIZE-1:0] mem_rdata_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_addr_o,
  output logic [DSIZE-1:0] out_data_o,
  output logic             out_last_o
);

  // One extra pointer bit so DEPTH == 2**AW never wraps; the end of the
  // walk is detected by comparing against DEPTH-1, not by overflow.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  dump_state_t      state_reg, state_next;
  logic [AW:0]      ptr_reg, ptr_next;
  logic [DSIZE-1:0] data_reg, data_next;
  logic             is_last;

`ifdef PQR5_DUMP_CSUM_EN
  localparam logic [31:0] CSUM_ADDR = 32'(DEPTH) << BYTE_SHIFT;
  logic [DSIZE-1:0] csum_reg, csum_next;
`endif

  assign is_last = (ptr_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      data_reg  <= '0;
`ifdef PQR5_DUMP_CSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      data_reg  <= data_next;
`ifdef PQR5_DUMP_CSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    data_next   = data_reg;
`ifdef PQR5_DUMP_CSUM_EN
    csum_next   = csum_reg;
`endif
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mem_re_o    = 1'b0;
    mem_addr_o  = '0;
    out_valid_o = 1'b0;
    out_addr_o  = '0;
    out_data_o  = '0;
    out_last_o  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          ptr_next   = '0;
`ifdef PQR5_DUMP_CSUM_EN
          csum_next  = '0;
`endif
          state_next = FETCH;
        end
      end

      FETCH: begin
        busy_o     = 1'b1;
        mem_re_o   = 1'b1;
        mem_addr_o = ptr_reg[AW-1:0];
        state_next = LATCH;
      end

      // RAM data is valid in this cycle (one cycle after the read enable).
      LATCH: begin
        busy_o     = 1'b1;
        data_next  = mem_rdata_i;
`ifdef PQR5_DUMP_CSUM_EN
        csum_next  = csum_reg ^ mem_rdata_i;
`endif
        state_next = EMIT;
      end

      // Beat fields come straight from registers, so they hold stable
      // for as long as the sink stalls.
      EMIT: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        out_addr_o  = 32'(ptr_reg) << BYTE_SHIFT;
        out_data_o  = data_reg;
`ifdef PQR5_DUMP_CSUM_EN
        out_last_o  = 1'b0;
        if (out_ready_i) begin
          if (is_last) begin
            state_next = CSUM;
          end else begin
            ptr_next   = ptr_reg + (AW+1)'(1);
            state_next = FETCH;
          end
        end
`else
        out_last_o  = is_last;
        if (out_ready_i) begin
          if (is_last) begin
            state_next = DONE;
          end else begin
            ptr_next   = ptr_reg + (AW+1)'(1);
            state_next = FETCH;
          end
        end
`endif
      end

`ifdef PQR5_DUMP_CSUM_EN
      CSUM: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        out_addr_o  = CSUM_ADDR;
        out_data_o  = csum_reg;
        out_last_o  = 1'b1;
        if (out_ready_i) begin
          state_next = DONE;
        end
      end
`endif

      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
